// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation datapath:
// default widths, controller state encoding and multiplier latency.
package dh_pkg;

    localparam int DH_WIDTH     = 32;
    localparam int DH_EXP_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REDUCE = 3'd2,
        S_STEP   = 3'd3,
        S_FINISH = 3'd4
    } dh_state_e;

    // Cycles from a mod_mul start pulse to its done pulse.
    function automatic int mul_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: p = a*b mod m without ever forming
// the full double-width product. Requires b < m and m >= 2; a may be any value.
module mod_mul
    import dh_pkg::*;
#(
    parameter int WIDTH = DH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_s;

    // acc < m, so 2*acc + b < 3m fits in WIDTH+2 bits and two subtractions restore acc < m.
    function automatic logic [WIDTH-1:0] mac_step(input logic [WIDTH-1:0] acc,
                                                   input logic             bit_i,
                                                   input logic [WIDTH-1:0] mult,
                                                   input logic [WIDTH-1:0] mod);
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] mm;
        mm = {2'b00, mod};
        t  = {1'b0, acc, 1'b0} + (bit_i ? {2'b00, mult} : {(WIDTH+2){1'b0}});
        if (t >= mm) t = t - mm;
        else         t = t;
        if (t >= mm) t = t - mm;
        else         t = t;
        return t[WIDTH-1:0];
    endfunction

    // Next-state logic: load on start, then one multiplier bit per cycle MSB first.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        acc_d  = acc_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        step_s = mac_step(acc_q, a_q[WIDTH-1], b_q, m_q);
        if (start) begin
            a_d   = a;
            b_d   = b;
            m_d   = m;
            acc_d = {WIDTH{1'b0}};
            cnt_d = CNT_W'(WIDTH);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = step_s;
            a_d   = {a_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
                p_d    = step_s;
            end else begin
                run_d  = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            m_q    <= {WIDTH{1'b0}};
            acc_q  <= {WIDTH{1'b0}};
            p_q    <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation engine with a
// start/busy/done handshake; two mod_mul units run the square and multiply in parallel.
module mod_exp_engine
    import dh_pkg::*;
#(
    parameter int WIDTH     = DH_WIDTH,
    parameter int EXP_WIDTH = DH_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result
);

    localparam logic [WIDTH-1:0]     ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ZERO_W = {WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0] ZERO_E = {EXP_WIDTH{1'b0}};

    dh_state_e            state_q, state_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic                 launch_q, launch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 step_go_s;

    logic                 sq_start_s, ml_start_s;
    logic [WIDTH-1:0]     sq_a_s, sq_b_s, ml_a_s, ml_b_s;
    logic                 sq_done, ml_done;
    logic [WIDTH-1:0]     sq_p, ml_p;

    // Controller next-state; b_q holds the raw base until REDUCE replaces it with base mod m.
    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mod_d     = mod_q;
        e_d       = e_q;
        launch_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        result_d  = result_q;
        step_go_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    busy_d  = 1'b1;
                    b_d     = base;
                    e_d     = exponent;
                    mod_d   = modulus;
                    acc_d   = ONE_W;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (mod_q <= ONE_W) begin
                    state_d  = S_FINISH;
                end else begin
                    launch_d = 1'b1;
                    state_d  = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (sq_done) begin
                    b_d = sq_p;
                    if (e_q == ZERO_E) begin
                        state_d   = S_FINISH;
                    end else begin
                        step_go_s = 1'b1;
                        state_d   = S_STEP;
                    end
                end else begin
                    state_d = S_REDUCE;
                end
            end
            S_STEP: begin
                if (sq_done && ml_done) begin
                    b_d   = sq_p;
                    acc_d = ml_p;
                    e_d   = e_q >> 1;
                    if (e_d == ZERO_E) begin
                        state_d   = S_FINISH;
                    end else begin
                        step_go_s = 1'b1;
                        state_d   = S_STEP;
                    end
                end else begin
                    state_d = S_STEP;
                end
            end
            S_FINISH: begin
                result_d = (mod_q <= ONE_W) ? ZERO_W : acc_q;
                err_d    = (mod_q == ZERO_W);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Next steps launch on the same edge the previous results land, so operands come from the _d values.
    always_comb begin
        sq_start_s = launch_q | step_go_s;
        sq_a_s     = launch_q ? b_q : b_d;
        sq_b_s     = launch_q ? ONE_W : b_d;
        ml_start_s = step_go_s;
        ml_a_s     = acc_d;
        ml_b_s     = e_d[0] ? b_d : ONE_W;
    end

    // Controller and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            b_q      <= ZERO_W;
            acc_q    <= ZERO_W;
            mod_q    <= ZERO_W;
            e_q      <= ZERO_E;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= ZERO_W;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mod_q    <= mod_d;
            e_q      <= e_d;
            launch_q <= launch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    mod_mul #(.WIDTH(WIDTH)) u_square (
        .clk   (clk),
        .rst   (rst),
        .start (sq_start_s),
        .a     (sq_a_s),
        .b     (sq_b_s),
        .m     (mod_q),
        .done  (sq_done),
        .p     (sq_p)
    );

    mod_mul #(.WIDTH(WIDTH)) u_multiply (
        .clk   (clk),
        .rst   (rst),
        .start (ml_start_s),
        .a     (ml_a_s),
        .b     (ml_b_s),
        .m     (mod_q),
        .done  (ml_done),
        .p     (ml_p)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine: directed vectors plus random operands
// checked against a 64-bit arithmetic model of base^exponent mod modulus.
module tb_mod_exp_engine;

    localparam int W  = 32;
    localparam int EW = 32;
    localparam int TIMEOUT = 1300;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base = 32'd0;
    logic [EW-1:0] exponent = 32'd0;
    logic [W-1:0]  modulus = 32'd0;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  result;

    int total = 0;
    int bad   = 0;

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                               input logic [31:0] m);
        logic [63:0] r, bb, mm;
        if (m == 32'd0) return 32'd0;
        mm = {32'd0, m};
        r  = 64'd1 % mm;
        bb = {32'd0, b} % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] e, input logic [31:0] m);
        int len;
        if (m <= 32'd1) return 2;
        len = 0;
        for (int i = 0; i < 32; i++) if (e[i]) len = i + 1;
        return 3 + (len + 1) * (W + 1);
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                            input bit hold);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        base = $urandom; exponent = $urandom; modulus = $urandom;
    endtask

    // Counts edges since the accepting edge until done is observed.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic er,
                             output bit ok);
        lat = 0; ok = 1'b0; res = 32'd0; er = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                res = result; er = err; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset_in: busy/done/err=%b result=%0d want 000 and 0", {busy, done, err}, result);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset_out: busy/done/err=%b result=%0d want 000 and 0", {busy, done, err}, result);
        end
    endtask

    task automatic test_dh_public;
        int lat; logic [31:0] res; logic er; bit ok;
        start_op(32'd5, 32'd6, 32'd23, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL dh_busy: got %b want 1", busy); end
        wait_done(lat, res, er, ok);
        total++;
        if (!ok || res !== 32'd8) begin bad++; $display("FAIL dh_result: got %0d want 8 (done seen=%0d)", res, ok); end
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL dh_err: got %b want 0", er); end
        total++;
        if (lat !== 3 + 4 * (W + 1)) begin bad++; $display("FAIL dh_latency: got %0d want %0d", lat, 3 + 4 * (W + 1)); end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dh_pulse: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_vectors;
        logic [31:0] vb [5] = '{32'd4, 32'd30, 32'd7, 32'd9, 32'd9};
        logic [31:0] ve [5] = '{32'd13, 32'd2, 32'd0, 32'd5, 32'd5};
        logic [31:0] vm [5] = '{32'd497, 32'd23, 32'd23, 32'd1, 32'd0};
        logic [31:0] vr [5] = '{32'd445, 32'd3, 32'd1, 32'd0, 32'd0};
        logic        vx [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          vl [5] = '{3 + 5 * (W + 1), 3 + 3 * (W + 1), 3 + (W + 1), 2, 2};
        int lat; logic [31:0] res; logic er; bit ok;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_op(vb[k], ve[k], vm[k], 1'b0);
            wait_done(lat, res, er, ok);
            total++;
            if (!ok || res !== vr[k]) begin bad++; $display("FAIL vec%0d_result: got %0d want %0d", k, res, vr[k]); end
            total++;
            if (er !== vx[k]) begin bad++; $display("FAIL vec%0d_err: got %b want %b", k, er, vx[k]); end
            total++;
            if (lat !== vl[k]) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, vl[k]); end
        end
    endtask

    task automatic test_full_width;
        int lat; logic [31:0] res; logic er; bit ok; logic [31:0] want;
        want = ref_modexp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        @(negedge clk);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        wait_done(lat, res, er, ok);
        total++;
        if (!ok || res !== want) begin bad++; $display("FAIL full_result: got %h want %h", res, want); end
        total++;
        if (lat !== 3 + 33 * 33) begin bad++; $display("FAIL full_latency: got %0d want %0d", lat, 3 + 33 * 33); end
    endtask

    task automatic test_random;
        int lat; logic [31:0] res; logic er; bit ok;
        logic [31:0] b, e, m;
        for (int k = 0; k < 6; k++) begin
            b = $urandom;
            e = $urandom >> $urandom_range(31, 0);
            m = (k == 0) ? 32'd2 : ($urandom >> $urandom_range(28, 0)) | 32'd2;
            @(negedge clk);
            start_op(b, e, m, 1'b0);
            wait_done(lat, res, er, ok);
            total++;
            if (!ok || res !== ref_modexp(b, e, m)) begin
                bad++;
                $display("FAIL rand%0d_result: %0d^%0d mod %0d got %0d want %0d", k, b, e, m, res, ref_modexp(b, e, m));
            end
            total++;
            if (lat !== ref_latency(e, m)) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, ref_latency(e, m)); end
        end
    endtask

    task automatic test_handshake;
        int lat; logic [31:0] res; logic er; bit ok; int extra;
        @(negedge clk);
        start_op(32'd4, 32'd13, 32'd497, 1'b1);
        wait_done(lat, res, er, ok);
        start = 1'b0;
        total++;
        if (!ok || res !== 32'd445) begin bad++; $display("FAIL hold_result: got %0d want 445", res); end
        total++;
        if (lat !== 3 + 5 * (W + 1)) begin bad++; $display("FAIL hold_latency: got %0d want %0d", lat, 3 + 5 * (W + 1)); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL hold_single_done: got %0d extra busy/done cycles want 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] res; logic er; bit ok;
        @(negedge clk);
        start_op(32'd5, 32'd6, 32'd23, 1'b0);
        wait_done(lat, res, er, ok);
        total++;
        if (!ok || res !== 32'd8) begin bad++; $display("FAIL b2b_first: got %0d want 8", res); end
        start_op(32'd30, 32'd2, 32'd23, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        wait_done(lat, res, er, ok);
        total++;
        if (!ok || res !== 32'd3) begin bad++; $display("FAIL b2b_second: got %0d want 3", res); end
        total++;
        if (lat !== 3 + 3 * (W + 1)) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, 3 + 3 * (W + 1)); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] res; logic er; bit ok; int seen;
        @(negedge clk);
        start_op(32'd5, 32'h0000_FFFF, 32'd1000003, 1'b0);
        repeat (60) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 32'd0) begin
            bad++;
            $display("FAIL rst_async: busy/done/err=%b result=%0d want 000 and 0", {busy, done, err}, result);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_no_done: got %0d busy/done cycles want 0", seen); end
        start_op(32'd4, 32'd13, 32'd497, 1'b0);
        wait_done(lat, res, er, ok);
        total++;
        if (!ok || res !== 32'd445) begin bad++; $display("FAIL rst_after_result: got %0d want 445", res); end
        total++;
        if (lat !== 3 + 5 * (W + 1)) begin bad++; $display("FAIL rst_after_latency: got %0d want %0d", lat, 3 + 5 * (W + 1)); end
    endtask

    initial begin
        test_reset();
        test_dh_public();
        test_vectors();
        test_full_width();
        test_random();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
